mem_dump_uart_tx: RTL and testbench
===================================

# mem_dump_uart_tx

Host-bound dump engine: on a start pulse it reads 16-bit words from a synchronous memory read port, addresses 0 through a programmed last address, and serializes each word as two 8N1 UART bytes, low byte first. It is the return path for the UART instruction loader. The host sends a program in over RX, and this block streams memory contents back out over TX so the host can read back the loaded image or inspect results. It sits on the CPU clock domain beside the instruction/data memory and drives the board TX pin.

## Interface
- CLKS_PER_BIT, 868, clock cycles per UART bit; 868 gives 115200 baud at 100 MHz. Legal range is 4 to 65535.
- ADDR_WIDTH, 8, memory address width.
- DATA_WIDTH, 16, memory word width. It is fixed at 16, so one word is sent as 2 bytes.

- i_clk  in  1  sole clock; all logic is rising-edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  single-cycle start request; honoured only in IDLE.
- i_last_addr  in  ADDR_WIDTH  last address to dump (inclusive); sampled on the accepted start.
- o_rd_addr  out  ADDR_WIDTH  memory read address.
- i_rd_data  in  DATA_WIDTH  memory read data; valid 1 cycle after o_rd_addr is presented.
- o_tx  out  1  serial line; idles high.
- o_busy  out  1  high from the cycle after an accepted start until o_done.
- o_done  out  1  one-cycle pulse after the final stop bit of the last word.

## Operation
- Reset values:
  - o_tx=1, o_busy=0, o_done=0, o_rd_addr=0.
  - State is IDLE; all counters are 0.
  - Reset takes effect immediately, including mid-frame; the line returns high asynchronously.
- Top FSM states: IDLE → FETCH → LATCH → SEND_LO → SEND_HI → (NEXT → FETCH | FIN) → IDLE.
  - IDLE: on i_start, capture i_last_addr into last_q, set o_rd_addr=0 and o_busy=1, then go to FETCH.
  - FETCH: wait one cycle for the memory read latency, then go to LATCH.
  - LATCH: register i_rd_data into word_q, issue the low byte to the byte transmitter, then go to SEND_LO.
  - SEND_LO: on the byte transmitter's done, issue the high byte, then go to SEND_HI.
  - SEND_HI: on the byte transmitter's done:
    - if o_rd_addr == last_q, go to FIN;
    - otherwise increment o_rd_addr and go to FETCH (NEXT is folded into this transition).
  - FIN: o_done=1 for 1 cycle, o_busy=0, then go to IDLE.
- Byte frame format:
  - 1 start bit (0), then 8 data bits LSB first, then 1 stop bit (1).
  - Each bit is held exactly CLKS_PER_BIT cycles.
- The address compare happens before the increment. Consequences:
  - i_last_addr=255 dumps all 256 words, and the counter never wraps.
  - i_last_addr=0 dumps exactly one word.
- i_start while busy is ignored: no restart and no queuing.
- i_start on the same cycle as o_done is ignored; a new start is accepted from the following cycle.
- Changes to i_last_addr after the start has been accepted have no effect.

## Timing
- Start latency: the start bit of the first byte begins on o_tx 3 cycles after the cycle in which i_start is sampled high (FETCH, then LATCH, then line driven low).
- Byte frame: 10×CLKS_PER_BIT cycles, which is 8680 cycles at the default.
- The high byte's start bit follows the low byte's stop bit with at most 1 idle cycle.
- Inter-word gap: 2 to 3 cycles of line-high. This gap covers the FETCH and LATCH re-read.
- Total dump time is (last+1)×(20×CLKS_PER_BIT + gap) cycles, within ±3 cycles per word.
- o_done rises 1 cycle after the last stop bit completes.

## Structure
- Shared package holds:
  - the UART_IDLE=1'b1 constant;
  - the frame bit count (10);
  - the top-level state encoding, as a localparam set.
- Sub-module uart_tx_byte contains the bit-timing and bit-shift logic.
  - Ports: i_clk, i_rst_n, i_valid, i_byte[7:0], o_tx, o_ready, o_done.
  - It holds a bit-clock counter of width clog2(CLKS_PER_BIT) and a 4-bit bit index.
  - i_valid is accepted only when o_ready=1.
- The top level holds the dump FSM, the address counter, last_q and word_q.

## Test plan
- Single word:
  - Stimulus: mem[0]=16'hA55A, i_last_addr=0, i_start.
  - Required response: the bytes 8'h5A then 8'hA5 are decoded from o_tx at 8680 cycles per frame; o_done fires once; o_busy is high for about 17363 cycles.
- Multi-word order:
  - Stimulus: mem[0..2]=16'h3C2B, 16'h10A5, 16'hFFFF, i_last_addr=2.
  - Required response: the byte stream 2B 3C A5 10 FF FF, and o_rd_addr steps 0, 1, 2.
- Full range:
  - Stimulus: i_last_addr=255, with mem[a]={a, ~a}.
  - Required response: 512 bytes received, ending with the pair 8'h00, 8'hFF; o_rd_addr never wraps to 0 before o_done.
- Start ignored while busy:
  - Stimulus: pulse i_start, then pulse it again mid-frame and on the o_done cycle.
  - Required response: exactly one dump; the second o_done occurs only after a later, valid start.
- Reset mid-frame:
  - Stimulus: assert i_rst_n=0 during data bit 4 of the low byte.
  - Required response: o_tx=1 in the same cycle; o_busy=0 and o_rd_addr=0; the next start produces a clean dump from address 0.
- Reduced-rate timing (CLKS_PER_BIT=4):
  - Required response: every bit is held exactly 4 cycles, and the start latency is 3 cycles.

Source files
------------

// File: rtl/mem_dump_uart_tx_pkg.sv
// Shared constants and dump FSM state encoding for the memory dump UART transmitter.
package mem_dump_uart_tx_pkg;

   localparam logic UART_IDLE  = 1'b1;
   localparam int   FRAME_BITS = 10;

   typedef logic [2:0] dump_state_t;

   localparam dump_state_t ST_IDLE    = 3'd0;
   localparam dump_state_t ST_FETCH   = 3'd1;
   localparam dump_state_t ST_LATCH   = 3'd2;
   localparam dump_state_t ST_SEND_LO = 3'd3;
   localparam dump_state_t ST_SEND_HI = 3'd4;
   localparam dump_state_t ST_FIN     = 3'd5;

endpackage

// File: rtl/mem_dump_uart_tx_uart_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit, each held CLKS_PER_BIT cycles.
module uart_tx_byte
   import mem_dump_uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_valid,
   input  logic [7:0] i_byte,
   output logic       o_tx,
   output logic       o_ready,
   output logic       o_done
);

   localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]       LAST_BIT = 4'(FRAME_BITS - 1);

   logic [CNT_W-1:0]      bit_cnt_q;
   logic [3:0]            bit_idx_q;
   logic [FRAME_BITS-1:0] frame_q;
   logic                  busy_q;
   logic                  tx_q;
   logic                  done_q;

   // bit_cnt_q is a per-bit down-counter; terminal count advances to the next frame bit
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bit_cnt_q <= '0;
         bit_idx_q <= '0;
         frame_q   <= '0;
         busy_q    <= 1'b0;
         tx_q      <= UART_IDLE;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (!busy_q) begin
            if (i_valid) begin
               frame_q   <= {UART_IDLE, i_byte, 1'b0};
               tx_q      <= 1'b0;
               busy_q    <= 1'b1;
               bit_idx_q <= '0;
               bit_cnt_q <= CNT_LOAD;
            end
         end else if (bit_cnt_q != '0) begin
            bit_cnt_q <= bit_cnt_q - 1'b1;
         end else if (bit_idx_q == LAST_BIT) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            tx_q   <= UART_IDLE;
         end else begin
            bit_idx_q <= bit_idx_q + 4'd1;
            tx_q      <= frame_q[1];
            frame_q   <= {UART_IDLE, frame_q[FRAME_BITS-1:1]};
            bit_cnt_q <= CNT_LOAD;
         end
      end
   end

   assign o_tx    = tx_q;
   assign o_ready = !busy_q;
   assign o_done  = done_q;

endmodule

// File: rtl/mem_dump_uart_tx.sv
// Dumps memory words 0..last over UART TX, two 8N1 bytes per 16-bit word, low byte first.
module mem_dump_uart_tx
   import mem_dump_uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int ADDR_WIDTH   = 8,
   parameter int DATA_WIDTH   = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_last_addr,
   output logic [ADDR_WIDTH-1:0] o_rd_addr,
   input  logic [DATA_WIDTH-1:0] i_rd_data,
   output logic                  o_tx,
   output logic                  o_busy,
   output logic                  o_done
);

   // state    | meaning
   // IDLE     | waiting for i_start
   // FETCH    | read address presented, waiting out memory latency
   // LATCH    | read data valid; low byte handed to the serializer
   // SEND_LO  | low byte on the line; high byte issued on its done
   // SEND_HI  | high byte on the line; on done, finish or step address
   // FIN      | one-cycle o_done pulse

   dump_state_t state_q, state_d;

   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] last_q;
   logic [DATA_WIDTH-1:8] word_q;  // low byte goes straight from read data in LATCH
   logic                  tx_valid;
   logic [7:0]            tx_byte;
   logic                  tx_ready;
   logic                  tx_done;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (i_start) state_d = ST_FETCH;
         ST_FETCH:   state_d = ST_LATCH;
         ST_LATCH:   if (tx_ready) state_d = ST_SEND_LO;
         ST_SEND_LO: if (tx_done) state_d = ST_SEND_HI;
         ST_SEND_HI: if (tx_done) state_d = (addr_q == last_q) ? ST_FIN : ST_FETCH;
         ST_FIN:     state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      tx_valid = 1'b0;
      tx_byte  = '0;
      o_busy   = 1'b0;
      o_done   = 1'b0;
      case (state_q)
         ST_FETCH:   o_busy = 1'b1;
         ST_LATCH: begin
            o_busy   = 1'b1;
            tx_valid = tx_ready;
            tx_byte  = i_rd_data[7:0];
         end
         ST_SEND_LO: begin
            o_busy   = 1'b1;
            tx_valid = tx_done;
            tx_byte  = word_q;
         end
         ST_SEND_HI: o_busy = 1'b1;
         ST_FIN:     o_done = 1'b1;
         default:    ;
      endcase
   end

   // compare precedes increment, so last=all-ones never wraps the address
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         addr_q <= '0;
         last_q <= '0;
         word_q <= '0;
      end else begin
         if (state_q == ST_IDLE && i_start) begin
            addr_q <= '0;
            last_q <= i_last_addr;
         end
         if (state_q == ST_LATCH) word_q <= i_rd_data[DATA_WIDTH-1:8];
         if (state_q == ST_SEND_HI && tx_done && addr_q != last_q)
            addr_q <= addr_q + ADDR_WIDTH'(1);
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx_byte (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_valid(tx_valid),
      .i_byte (tx_byte),
      .o_tx   (o_tx),
      .o_ready(tx_ready),
      .o_done (tx_done)
   );

   assign o_rd_addr = addr_q;

endmodule

// File: tb/tb_mem_dump_uart_tx.sv
// Bench for mem_dump_uart_tx: a fast instance (4 clocks/bit) for waveform-exact checks, a default-rate one for the single-word dump.
module tb_mem_dump_uart_tx;

   logic        clk_sys = 1'b0;
   logic        rst_b;
   logic        start_f, start_s;
   logic [7:0]  last_addr;
   logic [7:0]  rd_addr_f, rd_addr_s;
   logic [15:0] rd_data_f, rd_data_s;
   logic        tx_f, busy_f, done_f;
   logic        tx_s, busy_s, done_s;
   logic [15:0] mem [256];

   int checks = 0, failures = 0, cyc = 0;
   int busy_cnt_f = 0, done_cnt_f = 0, low_cnt_f = 0, wrap_cnt_f = 0;
   int busy_cnt_s = 0, done_cnt_s = 0;
   logic       busy_prev_f = 1'b0;
   logic [7:0] addr_prev_f = 8'd0;

   always #5 clk_sys = ~clk_sys;
   always @(posedge clk_sys) cyc <= cyc + 1;

   always @(posedge clk_sys) begin
      rd_data_f <= mem[rd_addr_f];
      rd_data_s <= mem[rd_addr_s];
   end

   always @(negedge clk_sys) begin
      if (busy_f === 1'b1) busy_cnt_f <= busy_cnt_f + 1;
      if (done_f === 1'b1) done_cnt_f <= done_cnt_f + 1;
      if (tx_f === 1'b0)   low_cnt_f  <= low_cnt_f + 1;
      if (busy_s === 1'b1) busy_cnt_s <= busy_cnt_s + 1;
      if (done_s === 1'b1) done_cnt_s <= done_cnt_s + 1;
      if (busy_f === 1'b1 && busy_prev_f && rd_addr_f < addr_prev_f) wrap_cnt_f <= wrap_cnt_f + 1;
      busy_prev_f <= (busy_f === 1'b1);
      addr_prev_f <= rd_addr_f;
   end

   mem_dump_uart_tx #(.CLKS_PER_BIT(4), .ADDR_WIDTH(8), .DATA_WIDTH(16)) dut_fast (
      .i_clk(clk_sys), .i_rst_n(rst_b), .i_start(start_f), .i_last_addr(last_addr),
      .o_rd_addr(rd_addr_f), .i_rd_data(rd_data_f), .o_tx(tx_f), .o_busy(busy_f), .o_done(done_f)
   );

   mem_dump_uart_tx #(.CLKS_PER_BIT(868), .ADDR_WIDTH(8), .DATA_WIDTH(16)) dut_slow (
      .i_clk(clk_sys), .i_rst_n(rst_b), .i_start(start_s), .i_last_addr(last_addr),
      .o_rd_addr(rd_addr_s), .i_rd_data(rd_data_s), .o_tx(tx_s), .o_busy(busy_s), .o_done(done_s)
   );

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", nm, got, want);
      end
   endtask

   task automatic check_range(input string nm, input int got, input int lo, input int hi);
      checks++;
      if (got < lo || got > hi) begin
         failures++;
         $display("FAIL %s: got %0d want %0d..%0d", nm, got, lo, hi);
      end
   endtask

   // Fast instance: waits for a start bit, then compares every cycle of the 40-cycle frame.
   task automatic check_frame(input logic [7:0] exp, input string nm, output int ts, output logic [7:0] got);
      logic [9:0] fr;
      int w, bad;
      fr  = {1'b1, exp, 1'b0};
      w   = 0;
      bad = 0;
      got = '0;
      ts  = cyc;
      while (tx_f !== 1'b0 && w < 200) begin
         @(negedge clk_sys);
         w++;
      end
      checks++;
      if (tx_f !== 1'b0) begin
         failures++;
         $display("FAIL %s start: line %b after %0d cycles, want 0", nm, tx_f, w);
         return;
      end
      ts = cyc;
      for (int k = 0; k < 40; k++) begin
         if (tx_f !== fr[k/4]) bad++;
         if (k >= 4 && k < 36 && k % 4 == 2) got[k/4-1] = tx_f;
         @(negedge clk_sys);
      end
      checks++;
      if (bad != 0 || got !== exp) begin
         failures++;
         $display("FAIL %s frame: got byte %h with %0d bad samples, want %h", nm, got, bad, exp);
      end
   endtask

   // Slow instance: mid-bit sampling decoder.
   task automatic rx_slow(output logic [7:0] b, output int ts, output logic ok);
      int w;
      w  = 0;
      ok = 1'b1;
      b  = '0;
      ts = cyc;
      while (tx_s !== 1'b0 && w < 20000) begin
         @(negedge clk_sys);
         w++;
      end
      if (tx_s !== 1'b0) begin
         ok = 1'b0;
         return;
      end
      ts = cyc;
      repeat (434) @(negedge clk_sys);
      if (tx_s !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (868) @(negedge clk_sys);
         b[i] = tx_s;
      end
      repeat (868) @(negedge clk_sys);
      if (tx_s !== 1'b1) ok = 1'b0;
   endtask

   task automatic run_dump(input logic [7:0] last, input logic [47:0] exp, input string nm);
      int t0, ts, prev, dc, w;
      logic [7:0] got;
      dc = done_cnt_f;
      prev = 0;
      last_addr = last;
      start_f = 1'b1;
      t0 = cyc;
      @(negedge clk_sys);
      start_f = 1'b0;
      for (int k = 0; k < 2*(int'(last)+1); k++) begin
         check_frame(exp[8*k +: 8], $sformatf("%s byte%0d", nm, k), ts, got);
         if (k == 0)          check_range({nm, " start latency"}, ts - t0, 3, 3);
         else if (k % 2 == 1) check_range({nm, " lo-hi spacing"}, ts - prev, 40, 41);
         else                 check_range({nm, " word spacing"}, ts - prev, 42, 43);
         check($sformatf("%s rd_addr byte%0d", nm, k), {24'd0, rd_addr_f}, k/2);
         prev = ts;
      end
      w = 0;
      while (done_f !== 1'b1 && w < 10) begin
         @(negedge clk_sys);
         w++;
      end
      check({nm, " done pulse"}, {31'd0, done_f}, 1);
      repeat (2) @(negedge clk_sys);
      check({nm, " done count"}, done_cnt_f - dc, 1);
   endtask

   typedef struct packed {
      logic [7:0]  last;
      logic [47:0] words;  // {w2, w1, w0}
      logic [47:0] exp;    // expected byte k at [8k+:8]
   } vec_t;

   vec_t vecs [5];

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int t0, ts0, ts1, dc, bc, lc, wc, w, ts;
      logic [7:0] b0, b1, got, lo_last, hi_last, expb, av;
      logic ok0, ok1;

      vecs[0] = '{8'd0, 48'h0000_0000_A55A, 48'h0000_0000_A55A};
      vecs[1] = '{8'd2, 48'hFFFF_10A5_3C2B, 48'hFFFF_10A5_3C2B};
      vecs[2] = '{8'd1, 48'h0000_8000_0001, 48'h0000_8000_0001};
      vecs[3] = '{8'd0, 48'h0000_0000_00FF, 48'h0000_0000_00FF};
      vecs[4] = '{8'd2, 48'hC33C_0000_6996, 48'hC33C_0000_6996};

      for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
      rst_b = 1'b0;
      start_f = 1'b0;
      start_s = 1'b0;
      last_addr = 8'd0;
      repeat (3) @(negedge clk_sys);
      check("reset fast", {21'd0, tx_f, busy_f, done_f, rd_addr_f}, {21'd0, 1'b1, 1'b0, 1'b0, 8'd0});
      check("reset slow", {21'd0, tx_s, busy_s, done_s, rd_addr_s}, {21'd0, 1'b1, 1'b0, 1'b0, 8'd0});
      rst_b = 1'b1;
      repeat (2) @(negedge clk_sys);

      // single word at the default bit rate
      dc = done_cnt_s;
      bc = busy_cnt_s;
      mem[0] = 16'hA55A;
      last_addr = 8'd0;
      start_s = 1'b1;
      t0 = cyc;
      @(negedge clk_sys);
      start_s = 1'b0;
      rx_slow(b0, ts0, ok0);
      rx_slow(b1, ts1, ok1);
      check("slow lo byte", {24'd0, b0}, 8'h5A);
      check("slow hi byte", {24'd0, b1}, 8'hA5);
      check("slow framing", {30'd0, ok0, ok1}, 2'b11);
      check_range("slow start latency", ts0 - t0, 3, 3);
      check_range("slow frame spacing", ts1 - ts0, 8680, 8681);
      w = 0;
      while (done_s !== 1'b1 && w < 1000) begin
         @(negedge clk_sys);
         w++;
      end
      check("slow done pulse", {31'd0, done_s}, 1);
      repeat (2) @(negedge clk_sys);
      check("slow done count", done_cnt_s - dc, 1);
      check_range("slow busy cycles", busy_cnt_s - bc, 17361, 17367);

      for (int i = 0; i < 5; i++) begin
         for (int j = 0; j < 3; j++) mem[j] = vecs[i].words[16*j +: 16];
         run_dump(vecs[i].last, vecs[i].exp, $sformatf("vec%0d", i));
         repeat (3) @(negedge clk_sys);
      end

      // start while busy and on the o_done cycle is ignored; last_addr change mid-dump has no effect
      mem[0] = 16'h1234;
      dc = done_cnt_f;
      bc = busy_cnt_f;
      last_addr = 8'd0;
      start_f = 1'b1;
      @(negedge clk_sys);
      start_f = 1'b0;
      repeat (20) @(negedge clk_sys);
      last_addr = 8'd5;
      start_f = 1'b1;
      @(negedge clk_sys);
      start_f = 1'b0;
      w = 0;
      while (done_f !== 1'b1 && w < 300) begin
         @(negedge clk_sys);
         w++;
      end
      check("ignore done pulse", {31'd0, done_f}, 1);
      lc = low_cnt_f;
      start_f = 1'b1;
      @(negedge clk_sys);
      start_f = 1'b0;
      repeat (30) @(negedge clk_sys);
      check("ignore done count", done_cnt_f - dc, 1);
      check_range("ignore busy cycles", busy_cnt_f - bc, 81, 87);
      check("ignore line idle", low_cnt_f - lc, 0);
      check("ignore busy low", {31'd0, busy_f}, 0);
      run_dump(8'd0, 48'h0000_0000_1234, "restart");
      repeat (3) @(negedge clk_sys);

      // full 256-word range
      for (int a = 0; a < 256; a++) mem[a] = {8'(a), ~8'(a)};
      dc = done_cnt_f;
      wc = wrap_cnt_f;
      lo_last = '0;
      hi_last = '0;
      last_addr = 8'd255;
      start_f = 1'b1;
      @(negedge clk_sys);
      start_f = 1'b0;
      for (int k = 0; k < 512; k++) begin
         av = 8'(k/2);
         expb = (k % 2 == 1) ? av : ~av;
         check_frame(expb, $sformatf("full byte%0d", k), ts, got);
         if (k == 510) lo_last = got;
         if (k == 511) hi_last = got;
      end
      w = 0;
      while (done_f !== 1'b1 && w < 10) begin
         @(negedge clk_sys);
         w++;
      end
      check("full done pulse", {31'd0, done_f}, 1);
      repeat (2) @(negedge clk_sys);
      check("full last pair", {16'd0, lo_last, hi_last}, 16'h00FF);
      check("full done count", done_cnt_f - dc, 1);
      check("full no wrap", wrap_cnt_f - wc, 0);

      // reset during data bit 4 of word 1's low byte
      mem[0] = 16'h1234;
      mem[1] = 16'h00EF;
      mem[2] = 16'h5555;
      last_addr = 8'd2;
      start_f = 1'b1;
      @(negedge clk_sys);
      start_f = 1'b0;
      check_frame(8'h34, "rst w0 lo", ts, got);
      check_frame(8'h12, "rst w0 hi", ts, got);
      w = 0;
      while (tx_f !== 1'b0 && w < 20) begin
         @(negedge clk_sys);
         w++;
      end
      repeat (21) @(negedge clk_sys);
      check("pre-reset line/addr", {23'd0, tx_f, rd_addr_f}, {23'd0, 1'b0, 8'd1});
      rst_b = 1'b0;
      #1;
      check("async reset", {21'd0, tx_f, busy_f, done_f, rd_addr_f}, {21'd0, 1'b1, 1'b0, 1'b0, 8'd0});
      repeat (2) @(negedge clk_sys);
      rst_b = 1'b1;
      @(negedge clk_sys);
      run_dump(8'd1, 48'h0000_00EF_1234, "post-reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
